// File: rtl/mux_rr_nto1_if.sv
// Handshake bundle between N producers, the merge mux and its single consumer.
interface mux_rr_nto1_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SELW-1:0]           select;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SELW-1:0]           out_chan;

    // slave: the mux itself; master: the surrounding producers/consumer
    modport slave (
        input  in_data, in_valid, select, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

    modport master (
        output in_data, in_valid, select, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_rr_nto1.sv
// Registered N-to-1 merge with valid/ready handshake; fixed-select or round-robin grant.
module mux_rr_nto1 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RR_MODE  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_rr_nto1_if.slave bus
);
    localparam int unsigned SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SELW-1:0]     out_chan_q, out_chan_d;
    logic [SELW-1:0]     ptr_q, ptr_d;

    logic                space_c;
    logic                grant_vld_c;
    logic [SELW-1:0]     grant_idx_c;
    logic [WIDTH-1:0]    grant_data_c;
    logic [CHANNELS-1:0] in_ready_c;
    logic [31:0]         cand_c;

    // The output register can take a word whenever it is empty or draining.
    assign space_c = !out_valid_q || bus.out_ready;

    // Grant selection: rotating search from ptr_q, or the decoded SELECT.
    always_comb begin : grant_logic
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        if (RR_MODE != 0) begin
            for (int unsigned off = 0; off < CHANNELS; off++) begin
                cand_c = 32'(ptr_q) + off;
                if (cand_c >= CHANNELS) begin
                    cand_c = cand_c - CHANNELS;
                end
                if (!grant_vld_c && bus.in_valid[SELW'(cand_c)]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = SELW'(cand_c);
                end
            end
        end else begin
            // Out-of-range SELECT values match no channel and are never granted.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if ((bus.select == SELW'(i)) && bus.in_valid[SELW'(i)]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = SELW'(i);
                end
            end
        end
    end

    // One-hot ready and the granted channel's data word.
    always_comb begin : ready_data
        in_ready_c   = '0;
        grant_data_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant_idx_c == SELW'(i)) begin
                grant_data_c                = bus.in_data[i*WIDTH +: WIDTH];
                in_ready_c[SELW'(i)]        = grant_vld_c && space_c;
            end
        end
    end

    assign bus.in_ready = in_ready_c;

    // Next state: load on transfer, otherwise clear valid on a plain drain.
    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (grant_vld_c && space_c) begin
            out_data_d  = grant_data_c;
            out_chan_d  = grant_idx_c;
            out_valid_d = 1'b1;
            if (RR_MODE != 0) begin
                ptr_d = (32'(grant_idx_c) == (CHANNELS - 1)) ? '0 : grant_idx_c + SELW'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Self-checking bench for mux_rr_nto1: four configurations against a queue-free behavioural model.
module tb_mux_rr_nto1;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus and observed outputs, one slot per DUT (3-channel DUTs use the low bits).
    logic [3:0]  v    [NDUT];
    logic [31:0] d    [NDUT];
    logic [1:0]  sel  [NDUT];
    logic        ordy [NDUT];
    logic [3:0]  rdy  [NDUT];
    logic [7:0]  od   [NDUT];
    logic        ov   [NDUT];
    logic [1:0]  oc   [NDUT];

    mux_rr_nto1_if #(.WIDTH(8), .CHANNELS(4)) if0 ();
    mux_rr_nto1_if #(.WIDTH(8), .CHANNELS(4)) if1 ();
    mux_rr_nto1_if #(.WIDTH(8), .CHANNELS(3)) if2 ();
    mux_rr_nto1_if #(.WIDTH(8), .CHANNELS(3)) if3 ();

    mux_rr_nto1 #(.WIDTH(8), .CHANNELS(4), .RR_MODE(0)) u_fix4 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mux_rr_nto1 #(.WIDTH(8), .CHANNELS(4), .RR_MODE(1)) u_rr4  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux_rr_nto1 #(.WIDTH(8), .CHANNELS(3), .RR_MODE(1)) u_rr3  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mux_rr_nto1 #(.WIDTH(8), .CHANNELS(3), .RR_MODE(0)) u_fix3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if0.in_data = d[0];        assign if0.in_valid = v[0];
    assign if0.select  = sel[0];      assign if0.out_ready = ordy[0];
    assign rdy[0] = if0.in_ready;     assign od[0] = if0.out_data;
    assign ov[0]  = if0.out_valid;    assign oc[0] = if0.out_chan;

    assign if1.in_data = d[1];        assign if1.in_valid = v[1];
    assign if1.select  = sel[1];      assign if1.out_ready = ordy[1];
    assign rdy[1] = if1.in_ready;     assign od[1] = if1.out_data;
    assign ov[1]  = if1.out_valid;    assign oc[1] = if1.out_chan;

    assign if2.in_data = d[2][23:0];  assign if2.in_valid = v[2][2:0];
    assign if2.select  = sel[2];      assign if2.out_ready = ordy[2];
    assign rdy[2] = {1'b0, if2.in_ready}; assign od[2] = if2.out_data;
    assign ov[2]  = if2.out_valid;    assign oc[2] = if2.out_chan;

    assign if3.in_data = d[3][23:0];  assign if3.in_valid = v[3][2:0];
    assign if3.select  = sel[3];      assign if3.out_ready = ordy[3];
    assign rdy[3] = {1'b0, if3.in_ready}; assign od[3] = if3.out_data;
    assign ov[3]  = if3.out_valid;    assign oc[3] = if3.out_chan;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int ch_of(input int k);
        return (k < 2) ? 4 : 3;
    endfunction

    function automatic bit rr_of(input int k);
        return (k == 1) || (k == 2);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model state: output register contents and round-robin pointer.
    logic [7:0] m_out  [NDUT];
    logic       m_val  [NDUT];
    int         m_chan [NDUT];
    int         m_ptr  [NDUT];
    int         g_cap  [NDUT];
    bit         sp_cap [NDUT];
    logic [3:0] rdy_cap[NDUT];
    int         wt     [NDUT][4];

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_out[k] = 8'h00; m_val[k] = 1'b0; m_chan[k] = 0; m_ptr[k] = 0;
            for (int i = 0; i < 4; i++) wt[k][i] = 0;
        end
    endtask

    // Grant as the rules state it: first valid channel at or after ptr, or SELECT if in range and valid.
    function automatic int model_grant(input int k);
        int c = ch_of(k);
        if (rr_of(k)) begin
            for (int i = 0; i < c; i++) begin
                int idx = (m_ptr[k] + i) % c;
                if (v[k][idx]) return idx;
            end
            return -1;
        end
        if ((int'(sel[k]) < c) && v[k][sel[k]]) return int'(sel[k]);
        return -1;
    endfunction

    task automatic pre_edge();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            int g = model_grant(k);
            bit sp = !m_val[k] || ordy[k];
            logic [3:0] e;
            g_cap[k]   = g;
            sp_cap[k]  = sp;
            rdy_cap[k] = rdy[k];
            e = (g >= 0 && sp) ? 4'(1 << g) : 4'b0000;
            chk("in_ready", k, 32'(rdy[k]), 32'(e));
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            int c = ch_of(k);
            // Fairness is judged from the DUT's own grants while producers hold valid.
            if (rr_of(k) && ((rdy_cap[k] & v[k]) != 4'b0000)) begin
                for (int i = 0; i < c; i++) begin
                    if (rdy_cap[k][i] && v[k][i]) begin
                        chk("rr_wait_bound", k, 32'(wt[k][i] <= c - 1), 32'd1);
                        wt[k][i] = 0;
                    end else if (v[k][i]) wt[k][i]++;
                    else wt[k][i] = 0;
                end
            end
            if (g_cap[k] >= 0 && sp_cap[k]) begin
                m_out[k]  = 8'(d[k] >> (8 * g_cap[k]));
                m_chan[k] = g_cap[k];
                m_val[k]  = 1'b1;
                if (rr_of(k)) m_ptr[k] = (g_cap[k] + 1) % c;
            end else if (m_val[k] && ordy[k]) begin
                m_val[k] = 1'b0;
            end
            chk("out_valid", k, 32'(ov[k]), 32'(m_val[k]));
            chk("out_data",  k, 32'(od[k]), 32'(m_out[k]));
            chk("out_chan",  k, 32'(oc[k]), 32'(m_chan[k]));
        end
    endtask

    task automatic set_idle();
        for (int k = 0; k < NDUT; k++) begin
            v[k] = 4'b0000; d[k] = 32'h0; sel[k] = 2'd0; ordy[k] = 1'b1;
        end
    endtask

    typedef struct {
        int         dut;
        logic [3:0] vld;
        logic [31:0] dat;
        logic [1:0] sl;
        logic       ord;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [7:0] e_out;
        logic [1:0] e_chan;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int dut, input logic [3:0] vld, input logic [31:0] dat, input logic [1:0] sl,
                       input logic ord, input logic [3:0] e_rdy, input logic e_ov, input logic [7:0] e_out,
                       input logic [1:0] e_chan);
        vec_t t;
        t.dut = dut; t.vld = vld; t.dat = dat; t.sl = sl; t.ord = ord;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_out = e_out; t.e_chan = e_chan;
        tbl.push_back(t);
    endtask

    initial begin
        // Fixed mode, 4 channels: select 2, then an idle selected channel.
        add(0, 4'b1111, 32'h44332211, 2'd2, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        add(0, 4'b0111, 32'h44332211, 2'd3, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2);
        // Backpressure: hold 0xA5 for three stalled cycles, then drain+load on one edge.
        add(0, 4'b1111, 32'h443322A5, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0);
        add(0, 4'b1111, 32'h4433225A, 2'd1, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0);
        add(0, 4'b0110, 32'h11223344, 2'd2, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0);
        add(0, 4'b1011, 32'h99887766, 2'd3, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0);
        add(0, 4'b1111, 32'h44335A11, 2'd1, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1);
        // Round-robin skip and wrap: only channels 1 and 3 valid.
        add(1, 4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add(1, 4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        add(1, 4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add(1, 4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        // Round-robin rotation with all valid, one word per cycle.
        add(1, 4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add(1, 4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add(1, 4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        add(1, 4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        add(1, 4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add(1, 4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        // Three channels, round-robin.
        add(2, 4'b0111, 32'h00332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add(2, 4'b0111, 32'h00332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add(2, 4'b0111, 32'h00332211, 2'd0, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        add(2, 4'b0111, 32'h00332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        // Three channels, fixed: SELECT=3 is out of range.
        add(3, 4'b0111, 32'h00332211, 2'd3, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        add(3, 4'b0111, 32'h00332211, 2'd3, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        add(3, 4'b0111, 32'h00332211, 2'd2, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        add(3, 4'b0111, 32'h00332211, 2'd3, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2);

        // Reset held low with every input valid and the consumer ready.
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            v[k] = (k < 2) ? 4'b1111 : 4'b0111; d[k] = 32'h44332211; sel[k] = 2'd1; ordy[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_out_data",  k, 32'(od[k]), 32'h00);
            chk("rst_out_chan",  k, 32'(oc[k]), 32'd0);
        end
        rst_n = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            vec_t t = tbl[r];
            set_idle();
            v[t.dut] = t.vld; d[t.dut] = t.dat; sel[t.dut] = t.sl; ordy[t.dut] = t.ord;
            pre_edge();
            chk("vec_in_ready", t.dut, 32'(rdy[t.dut]), 32'(t.e_rdy));
            post_edge();
            chk("vec_out_valid", t.dut, 32'(ov[t.dut]), 32'(t.e_ov));
            chk("vec_out_data",  t.dut, 32'(od[t.dut]), 32'(t.e_out));
            chk("vec_out_chan",  t.dut, 32'(oc[t.dut]), 32'(t.e_chan));
        end

        // Reset asserted mid-cycle while a stalled word is held: it must vanish immediately.
        set_idle();
        v[0] = 4'b0001; d[0] = 32'h00000077;
        pre_edge();
        post_edge();
        v[0] = 4'b0000; ordy[0] = 1'b0;
        pre_edge();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("midrst_out_data",  0, 32'(od[0]), 32'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First edge after release accepts input.
        v[0] = 4'b0001; d[0] = 32'h00000077; ordy[0] = 1'b1;
        pre_edge();
        post_edge();
        chk("postrst_load_valid", 0, 32'(ov[0]), 32'd1);
        chk("postrst_load_data",  0, 32'(od[0]), 32'h77);

        // Random traffic with producers holding valid/data until accepted.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NDUT; k++) begin
                int c = ch_of(k);
                if (g_cap[k] >= 0 && sp_cap[k]) v[k][g_cap[k]] = 1'b0;
                for (int i = 0; i < c; i++) begin
                    if (!v[k][i] && ($urandom_range(0, 1) == 1)) begin
                        v[k][i] = 1'b1;
                        d[k][i*8 +: 8] = 8'($urandom);
                    end
                end
                sel[k]  = 2'($urandom_range(0, 3));
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            pre_edge();
            post_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_rr_nto1.md
# mux_rr_nto1

Parametrised, registered N-to-1 multiplexer with valid/ready handshaking and a selectable arbitration mode. It generalises the datapath 2-to-1 select into a CHANNELS-input, WIDTH-bit merge point with a one-entry output register. It sits between multiple producers (ALU result, memory read data, immediate path, future functional units) and a single consumer such as the register-file write port or a shared bus. The select either comes from the control unit (fixed mode) or from an internal round-robin pointer.

## Interface
- WIDTH, 8, data width in bits per channel.
- CHANNELS, 4, number of input channels; 2 or more, not required to be a power of two.
- RR_MODE, 0, arbitration mode. 0 = fixed: SELECT chooses the channel. 1 = round-robin: SELECT is ignored.
- SELW, $clog2(CHANNELS), width of SELECT and OUT_CHAN (derived; not overridden).
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IN_DATA  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- IN_VALID  input  CHANNELS  channel i has a word.
- IN_READY  output  CHANNELS  channel i word is accepted this cycle.
- SELECT  input  SELW  channel index in fixed mode.
- OUT  output  WIDTH  registered output word.
- OUT_VALID  output  1  OUT holds a word.
- OUT_READY  input  1  consumer accepts OUT this cycle.
- OUT_CHAN  output  SELW  source channel index of the word in OUT.

## Operation
- Space signal: space = !OUT_VALID | OUT_READY. The output register can load a new word in the same cycle it drains the old one.
- Fixed mode grant:
  - grant = SELECT when SELECT < CHANNELS and IN_VALID[SELECT] = 1.
  - Otherwise there is no grant. An out-of-range SELECT is never granted.
- Round-robin grant:
  - Search from pointer ptr upward, modulo CHANNELS.
  - Grant the first channel with IN_VALID set.
  - No grant if IN_VALID is all zero.
- Ready: IN_READY[i] = (grant == i) & space. At most one bit of IN_READY is set. IN_READY is combinational from IN_VALID, SELECT, ptr, OUT_VALID and OUT_READY.
- Input transfer on channel g: IN_VALID[g] & IN_READY[g] at the clock edge. On transfer:
  - OUT <= IN_DATA[g]
  - OUT_CHAN <= g
  - OUT_VALID <= 1
- Output drain without a new input: OUT_VALID & OUT_READY with no input transfer gives OUT_VALID <= 0. OUT and OUT_CHAN keep their last values.
- Stall: OUT_VALID & !OUT_READY holds OUT, OUT_CHAN and OUT_VALID stable. All IN_READY are 0.
- Pointer update (RR_MODE=1 only): on an input transfer from g, ptr <= g+1, wrapping to 0 when g = CHANNELS-1. With no transfer, ptr is unchanged. In fixed mode, ptr stays at 0.
- Fairness: a continuously valid channel waits at most CHANNELS-1 transfers before it is granted.
- Protocol: producers must not drop IN_VALID or change IN_DATA until accepted. The block does not make IN_VALID depend on IN_READY.

## Timing
- Reset (RESET low, asynchronous): OUT=0, OUT_VALID=0, OUT_CHAN=0, ptr=0, so all IN_READY evaluate to 0 only through grant logic.
- Reset mid-operation: a held word is discarded immediately, not delivered.
- Reset release: the first edge with RESET high may accept input.
- Latency: one cycle from input transfer to OUT_VALID=1 with that word.
- Throughput: one word per cycle while OUT_READY stays 1.
- SELECT or IN_VALID changes during a stall do not alter the held word. They only affect which channel is granted once space = 1.
- Same-cycle events:
  - Drain plus load on one edge: OUT is replaced and OUT_VALID stays 1.
  - Drain with no load: OUT_VALID falls.
- Combinational paths: OUT_READY to IN_READY, IN_VALID to IN_READY, and SELECT to IN_READY. No path from input to OUT.

## Test plan
- Reset: hold RESET low with all IN_VALID=1 and OUT_READY=1 → OUT=0x00, OUT_VALID=0, OUT_CHAN=0. Assert RESET low while OUT_VALID=1 → OUT_VALID drops before the next edge.
- Fixed mode (RR_MODE=0, CHANNELS=4): IN_DATA = {0x44,0x33,0x22,0x11}, all valid, SELECT=2, OUT_READY=1 → IN_READY=0100, and one cycle later OUT=0x33, OUT_CHAN=2. SELECT=3 with IN_VALID[3]=0 → IN_READY=0000, OUT_VALID falls.
- Round-robin rotation (RR_MODE=1): all four channels valid continuously, OUT_READY=1 → OUT_CHAN sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
- Skip and wrap (RR_MODE=1): only IN_VALID[3] and IN_VALID[1] set, ptr=0 → grants 1, 3, 1, 3. After granting 3, ptr=0.
- Backpressure: OUT_VALID=1 with OUT=0xA5 and OUT_READY=0 for 3 cycles while inputs change → OUT stays 0xA5 and IN_READY=0000. Raise OUT_READY → the next word loads on that same edge with no bubble.
- Non-power-of-two (CHANNELS=3, RR_MODE=1): all valid → OUT_CHAN sequence 0,1,2,0. Fixed mode with SELECT=3 → never granted.
